// File: rtl/sd_pkg.sv
// Shared definitions for the SD block sequencer: manager opcodes, host op codes, FSM states.
package sd_pkg;

    // Disk manager command opcodes (cmd_word[23:16])
    localparam logic [7:0] MGR_NOP       = 8'd0;
    localparam logic [7:0] MGR_INIT      = 8'd1;
    localparam logic [7:0] MGR_BLOCK     = 8'd2;
    localparam logic [7:0] MGR_OREAD     = 8'd3;
    localparam logic [7:0] MGR_OWRITE    = 8'd4;
    localparam logic [7:0] MGR_READ      = 8'd5;
    localparam logic [7:0] MGR_WRITEBYTE = 8'd6;
    localparam logic [7:0] MGR_READBYTE  = 8'd7;
    localparam logic [7:0] MGR_CLOSE     = 8'd8;
    localparam logic [7:0] MGR_BIGBLOCK  = 8'd9;

    // Host request codes
    localparam logic [1:0] OP_INIT  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_OPEN,
        ST_WAIT_OPEN,
        ST_XFER,
        ST_WAIT_XFER,
        ST_FETCH,
        ST_CLOSE,
        ST_WAIT_CLOSE,
        ST_FINISH
    } state_e;

    function automatic logic [23:0] mk_cmd(input logic [7:0] opc, input logic [15:0] arg);
        return {opc, arg};
    endfunction

endpackage

// File: rtl/sd_watchdog.sv
// Loadable down-counter that flags when a manager response has taken too long.
module sd_watchdog #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on every command strobe, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = CW'(TIMEOUT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/sd_block_sequencer.sv
// Turns one host request (INIT / READ block / WRITE block) into the disk manager's
// command-word sequence, one command outstanding at a time. Each issue state is
// entered with its command strobe already registered, then falls into its wait state.
module sd_block_sequencer
    import sd_pkg::*;
#(
    parameter int  BLOCK_BYTES = 512,
    parameter int  TIMEOUT     = 1000000,
    localparam int IDX_W       = $clog2(BLOCK_BYTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_start,
    input  logic [1:0]       op_code,
    input  logic [23:0]      op_block,
    output logic             busy,
    output logic             op_done,
    output logic             op_err,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic [IDX_W-1:0] byte_idx,
    output logic             wr_req,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic [23:0]      cmd_word,
    output logic             cmd_start,
    input  logic             cmd_done,
    input  logic             res_valid,
    input  logic [7:0]       res_data
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [23:0]      blk_q, blk_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             op_done_q, op_done_d;
    logic             op_err_q, op_err_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             wr_req_q, wr_req_d;
    logic [23:0]      cmd_word_q, cmd_word_d;
    logic             cmd_start_q, cmd_start_d;
    logic             expire;
    logic             last_byte;
    logic             open_ack;

    assign last_byte = (idx_q == IDX_W'(BLOCK_BYTES - 1));
    // OWRITE completes through the result channel, everything else through cmd_done
    assign open_ack  = (op_q == OP_WRITE) ? res_valid : cmd_done;

    sd_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .restart (cmd_start_d),
        .expire  (expire)
    );

    // Next-state and next-output logic for the request sequencer
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        blk_d       = blk_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        op_done_d   = 1'b0;
        op_err_d    = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = 8'h00;
        byte_idx_d  = byte_idx_q;
        wr_req_d    = wr_req_q;
        cmd_start_d = 1'b0;
        cmd_word_d  = 24'h000000;
        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    op_d   = op_code;
                    blk_d  = op_block;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    case (op_code)
                        OP_INIT: begin
                            state_d     = ST_OPEN;
                            cmd_start_d = 1'b1;
                            cmd_word_d  = mk_cmd(MGR_INIT, 16'h0000);
                        end
                        OP_READ, OP_WRITE: begin
                            state_d     = ST_HI;
                            cmd_start_d = 1'b1;
                            cmd_word_d  = mk_cmd(MGR_BIGBLOCK, {8'h00, op_block[23:16]});
                        end
                        default: begin
                            state_d   = ST_FINISH;
                            op_done_d = 1'b1;
                            op_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_HI: begin
                state_d     = ST_LO;
                cmd_start_d = 1'b1;
                cmd_word_d  = mk_cmd(MGR_BLOCK, blk_q[15:0]);
            end
            ST_LO: begin
                state_d     = ST_OPEN;
                cmd_start_d = 1'b1;
                cmd_word_d  = (op_q == OP_READ) ? mk_cmd(MGR_OREAD, 16'h0000)
                                                : mk_cmd(MGR_OWRITE, blk_q[15:0]);
            end
            ST_OPEN: begin
                state_d = ST_WAIT_OPEN;
            end
            ST_WAIT_OPEN: begin
                if (open_ack) begin
                    if (op_q == OP_INIT) begin
                        state_d   = ST_FINISH;
                        op_done_d = 1'b1;
                    end else if (op_q == OP_READ) begin
                        state_d     = ST_XFER;
                        cmd_start_d = 1'b1;
                        cmd_word_d  = mk_cmd(MGR_READ, 16'h0000);
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (expire) begin
                    state_d   = ST_FINISH;
                    op_done_d = 1'b1;
                    op_err_d  = 1'b1;
                end
            end
            ST_XFER: begin
                state_d = ST_WAIT_XFER;
            end
            ST_WAIT_XFER: begin
                if (cmd_done) begin
                    if (op_q == OP_READ) begin
                        state_d     = ST_FETCH;
                        cmd_start_d = 1'b1;
                        cmd_word_d  = mk_cmd(MGR_READBYTE, 16'h0000);
                    end else if (last_byte) begin
                        state_d     = ST_CLOSE;
                        cmd_start_d = 1'b1;
                        cmd_word_d  = mk_cmd(MGR_CLOSE, 16'h0000);
                    end else begin
                        state_d = ST_FETCH;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (expire) begin
                    state_d   = ST_FINISH;
                    op_done_d = 1'b1;
                    op_err_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (op_q == OP_READ) begin
                    // READBYTE was strobed on entry; wait for its data
                    if (res_valid) begin
                        rd_valid_d  = 1'b1;
                        rd_data_d   = res_data;
                        byte_idx_d  = idx_q;
                        cmd_start_d = 1'b1;
                        if (last_byte) begin
                            state_d    = ST_CLOSE;
                            cmd_word_d = mk_cmd(MGR_CLOSE, 16'h0000);
                        end else begin
                            state_d    = ST_XFER;
                            idx_d      = idx_q + IDX_W'(1);
                            cmd_word_d = mk_cmd(MGR_READ, 16'h0000);
                        end
                    end else if (expire) begin
                        state_d   = ST_FINISH;
                        op_done_d = 1'b1;
                        op_err_d  = 1'b1;
                    end
                end else begin
                    // Host-paced: no watchdog while waiting for wr_valid
                    if (!wr_req_q) begin
                        wr_req_d   = 1'b1;
                        byte_idx_d = idx_q;
                    end else if (wr_valid) begin
                        wr_req_d    = 1'b0;
                        state_d     = ST_XFER;
                        cmd_start_d = 1'b1;
                        cmd_word_d  = mk_cmd(MGR_WRITEBYTE, {8'h00, wr_data});
                    end
                end
            end
            ST_CLOSE: begin
                state_d = ST_WAIT_CLOSE;
            end
            ST_WAIT_CLOSE: begin
                if (cmd_done) begin
                    state_d   = ST_FINISH;
                    op_done_d = 1'b1;
                end else if (expire) begin
                    state_d   = ST_FINISH;
                    op_done_d = 1'b1;
                    op_err_d  = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                wr_req_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            blk_q       <= 24'h000000;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            op_done_q   <= 1'b0;
            op_err_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
            byte_idx_q  <= '0;
            wr_req_q    <= 1'b0;
            cmd_word_q  <= 24'h000000;
            cmd_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            blk_q       <= blk_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            op_done_q   <= op_done_d;
            op_err_q    <= op_err_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            byte_idx_q  <= byte_idx_d;
            wr_req_q    <= wr_req_d;
            cmd_word_q  <= cmd_word_d;
            cmd_start_q <= cmd_start_d;
        end
    end

    assign busy      = busy_q;
    assign op_done   = op_done_q;
    assign op_err    = op_err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign byte_idx  = byte_idx_q;
    assign wr_req    = wr_req_q;
    assign cmd_word  = cmd_word_q;
    assign cmd_start = cmd_start_q;

endmodule

// File: tb/tb_sd_block_sequencer.sv
// Self-checking bench for sd_block_sequencer: a behavioural disk manager and host,
// a passive logger, and per-scenario tasks checking against expected command lists.
`timescale 1ns/1ps
module tb_sd_block_sequencer;

    localparam int BB = 512;
    localparam int TO = 100;
    localparam logic [1:0] C_INIT = 2'd0, C_READ = 2'd1, C_WRITE = 2'd2, C_RSVD = 2'd3;

    typedef logic [23:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_start = 1'b0;
    logic [1:0]  op_code = 2'd0;
    logic [23:0] op_block = 24'h0;
    logic        busy, op_done, op_err, rd_valid, wr_req, cmd_start;
    logic [7:0]  rd_data;
    logic [8:0]  byte_idx;
    logic [23:0] cmd_word;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        cmd_done = 1'b0;
    logic        res_valid = 1'b0;
    logic [7:0]  res_data = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // manager-model knobs (written only by the main sequence)
    int mgr_lat = 0;          // 0 = random 1..4 cycles
    bit mgr_rand = 0;         // READBYTE data: 0 = byte count & 0xFF, 1 = random
    bit mgr_silent = 0;       // never answer OREAD
    int stray_at = -1;        // cycle at which to pulse cmd_done+res_valid unprompted

    // logs
    logic [23:0] cmd_log[$];
    int          cmd_cyc[$];
    logic [7:0]  rd_log[$];
    logic [8:0]  rd_ilog[$];
    logic [7:0]  mgr_bytes[$];
    logic [7:0]  wr_exp[$];
    logic [8:0]  wr_idx[$];
    int          done_n = 0, done_cyc = 0;
    logic        done_err = 1'b0;
    int          idle_word_viol = 0, busy_viol = 0;

    sd_block_sequencer #(.BLOCK_BYTES(BB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .op_start(op_start), .op_code(op_code), .op_block(op_block),
        .busy(busy), .op_done(op_done), .op_err(op_err), .rd_valid(rd_valid), .rd_data(rd_data),
        .byte_idx(byte_idx), .wr_req(wr_req), .wr_valid(wr_valid), .wr_data(wr_data),
        .cmd_word(cmd_word), .cmd_start(cmd_start), .cmd_done(cmd_done),
        .res_valid(res_valid), .res_data(res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Disk manager model: answers each command after a latency, drives on negedge
    int  m_pend = 0;
    bit  m_res = 0;
    logic [7:0] m_dat = 8'h00;
    int  m_rb = 0;
    int  m_lat = 1;
    initial forever begin
        @(negedge clk);
        cmd_done = 1'b0; res_valid = 1'b0; res_data = 8'h00;
        if (rst) begin
            m_pend = 0;
        end else if (cyc == stray_at) begin
            cmd_done = 1'b1; res_valid = 1'b1; res_data = 8'hA5;
        end else if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                if (m_res) begin res_valid = 1'b1; res_data = m_dat; end
                else cmd_done = 1'b1;
            end
        end
        if (cmd_start && !rst) begin
            m_lat = (mgr_lat != 0) ? mgr_lat : int'($urandom_range(1, 4));
            case (cmd_word[23:16])
                8'd1, 8'd5, 8'd6, 8'd8: begin m_pend = m_lat; m_res = 0; end
                8'd3: begin m_rb = 0; if (!mgr_silent) begin m_pend = m_lat; m_res = 0; end end
                8'd4: begin m_pend = m_lat; m_res = 1; m_dat = 8'h00; end
                8'd7: begin
                    m_pend = m_lat; m_res = 1;
                    m_dat = mgr_rand ? 8'($urandom) : 8'(m_rb);
                    mgr_bytes.push_back(m_dat);
                    m_rb++;
                end
                default: ;
            endcase
        end
    end

    // Host write-data model: supplies a random byte 3 cycles after wr_req rises
    int h_w = 0;
    initial forever begin
        @(negedge clk);
        wr_valid = 1'b0;
        if (wr_req && !rst) begin
            if (h_w == 3) begin
                wr_valid = 1'b1;
                wr_data = 8'($urandom);
                wr_exp.push_back(wr_data);
                wr_idx.push_back(byte_idx);
                h_w = 0;
            end else h_w++;
        end else h_w = 0;
    end

    // Passive logger of DUT outputs
    initial forever begin
        @(negedge clk);
        if (cmd_start) begin cmd_log.push_back(cmd_word); cmd_cyc.push_back(cyc); end
        else if (cmd_word !== 24'h0) idle_word_viol++;
        if (rd_valid) begin rd_log.push_back(rd_data); rd_ilog.push_back(byte_idx); end
        if (op_done) begin done_n++; done_cyc = cyc; done_err = op_err; if (!busy) busy_viol++; end
    end

    function automatic wq_t read_cmds(input logic [23:0] blk);
        wq_t q;
        q.push_back({8'h09, 8'h00, blk[23:16]});
        q.push_back({8'h02, blk[15:0]});
        q.push_back(24'h030000);
        for (int i = 0; i < BB; i++) begin q.push_back(24'h050000); q.push_back(24'h070000); end
        q.push_back(24'h080000);
        return q;
    endfunction

    function automatic wq_t write_cmds(input logic [23:0] blk, input int wb);
        wq_t q;
        q.push_back({8'h09, 8'h00, blk[23:16]});
        q.push_back({8'h02, blk[15:0]});
        q.push_back({8'h04, blk[15:0]});
        for (int i = 0; i < BB; i++) q.push_back({16'h0600, wr_exp[wb + i]});
        q.push_back(24'h080000);
        return q;
    endfunction

    // index of first difference between logged commands (from base) and exp; -1 equal, -2 length
    function automatic int seq_diff(input wq_t exp, input int base);
        if (cmd_log.size() - base != exp.size()) return -2;
        foreach (exp[i]) if (cmd_log[base + i] !== exp[i]) return i;
        return -1;
    endfunction

    task automatic start_op(input logic [1:0] code, input logic [23:0] blk, output int t);
        @(negedge clk);
        op_start = 1'b1; op_code = code; op_block = blk; t = cyc;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int n = 0;
        while (done_n == base && n < budget) begin @(negedge clk); #1; n++; end
        checks++;
        if (done_n == base) begin
            errors++;
            $display("FAIL %s: op_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, op_done, op_err, rd_valid, rd_data, byte_idx, wr_req, cmd_word, cmd_start} !== 47'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b cmd_start=%b cmd_word=%h rd_valid=%b wr_req=%b, required all 0",
                     busy, cmd_start, cmd_word, rd_valid, wr_req);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_init();
        int t, b, d;
        b = cmd_log.size(); d = done_n; mgr_lat = 5;
        start_op(C_INIT, 24'h0, t);
        wait_done(d, 50, "init_done");
        checks++;
        if (cmd_log.size() - b != 1 || cmd_log[b] !== 24'h010000) begin
            errors++;
            $display("FAIL init_cmd: got %0d words first=%h, required 1 word 010000", cmd_log.size() - b, cmd_log[b]);
        end
        checks++;
        if (cmd_cyc[b] != t + 1 || done_cyc != cmd_cyc[b] + 6 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL init_timing: cmd at %0d done at %0d err=%b, required cmd %0d done %0d err 0",
                     cmd_cyc[b], done_cyc, done_err, t + 1, t + 7);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_drop: got busy=%b, required 0", busy); end
        mgr_lat = 0;
    endtask

    task automatic test_read_pattern();
        int t, b, rb, d, k;
        wq_t exp;
        b = cmd_log.size(); rb = rd_log.size(); d = done_n; mgr_rand = 0;
        start_op(C_READ, 24'h12ABCD, t);
        wait_done(d, 20000, "read_done");
        exp = read_cmds(24'h12ABCD);
        k = seq_diff(exp, b);
        checks++;
        if (k != -1) begin
            errors++;
            $display("FAIL read_cmds: diff at %0d, got %0d words, required %0d", k, cmd_log.size() - b, exp.size());
        end
        checks++;
        if (cmd_cyc[b] != t + 1 || cmd_cyc[b + 1] != t + 2 || cmd_cyc[b + 2] != t + 3) begin
            errors++;
            $display("FAIL read_lead_timing: got %0d,%0d,%0d, required %0d,%0d,%0d",
                     cmd_cyc[b], cmd_cyc[b + 1], cmd_cyc[b + 2], t + 1, t + 2, t + 3);
        end
        k = -1;
        if (rd_log.size() - rb != BB) k = -2;
        else for (int i = 0; i < BB; i++)
            if (rd_log[rb + i] !== 8'(i) || rd_ilog[rb + i] !== 9'(i)) begin k = i; break; end
        checks++;
        if (k != -1) begin
            errors++;
            $display("FAIL read_data: diff at %0d, got %0d bytes, required %0d bytes of i&FF with idx i", k, rd_log.size() - rb, BB);
        end
        checks++;
        if (done_err !== 1'b0) begin errors++; $display("FAIL read_err: got %b, required 0", done_err); end
    endtask

    task automatic test_write();
        int t, b, wb, d, k;
        wq_t exp;
        b = cmd_log.size(); wb = wr_exp.size(); d = done_n;
        start_op(C_WRITE, 24'h000010, t);
        wait_done(d, 20000, "write_done");
        exp = write_cmds(24'h000010, wb);
        k = seq_diff(exp, b);
        checks++;
        if (k != -1) begin
            errors++;
            $display("FAIL write_cmds: diff at %0d, got %0d words, required %0d", k, cmd_log.size() - b, exp.size());
        end
        k = -1;
        if (wr_idx.size() - wb != BB) k = -2;
        else for (int i = 0; i < BB; i++) if (wr_idx[wb + i] !== 9'(i)) begin k = i; break; end
        checks++;
        if (k != -1) begin
            errors++;
            $display("FAIL write_idx: diff at %0d, got %0d requests, required %0d with idx i", k, wr_idx.size() - wb, BB);
        end
        checks++;
        if (done_err !== 1'b0) begin errors++; $display("FAIL write_err: got %b, required 0", done_err); end
    endtask

    task automatic test_timeout();
        int t, b, d;
        logic [23:0] blk;
        blk = 24'($urandom);
        b = cmd_log.size(); d = done_n; mgr_silent = 1;
        start_op(C_READ, blk, t);
        wait_done(d, 300, "timeout_done");
        checks++;
        if (cmd_log.size() - b != 3 || cmd_log[b] !== {8'h09, 8'h00, blk[23:16]} || cmd_log[b + 2] !== 24'h030000) begin
            errors++;
            $display("FAIL timeout_cmds: got %0d words first=%h, required 3 words first=%h", cmd_log.size() - b, cmd_log[b], {8'h09, 8'h00, blk[23:16]});
        end
        checks++;
        if (done_err !== 1'b1 || done_cyc != cmd_cyc[b + 2] + TO + 1) begin
            errors++;
            $display("FAIL timeout_timing: done at %0d err=%b, required %0d err 1", done_cyc, done_err, cmd_cyc[b + 2] + TO + 1);
        end
        mgr_silent = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignored();
        int t, b, d;
        // reserved op code
        b = cmd_log.size(); d = done_n;
        start_op(C_RSVD, 24'h0, t);
        wait_done(d, 10, "rsvd_done");
        checks++;
        if (done_cyc != t + 1 || done_err !== 1'b1 || cmd_log.size() != b) begin
            errors++;
            $display("FAIL rsvd: done at %0d err=%b cmds=%0d, required done %0d err 1 cmds 0", done_cyc, done_err, cmd_log.size() - b, t + 1);
        end
        // stray responses while idle
        repeat (2) @(negedge clk);
        b = cmd_log.size(); d = done_n; stray_at = cyc + 2;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (cmd_log.size() != b || done_n != d || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: cmds=%0d dones=%0d busy=%b, required 0 0 0", cmd_log.size() - b, done_n - d, busy);
        end
        stray_at = -1;
        // op_start while busy
        b = cmd_log.size(); d = done_n; mgr_lat = 5;
        start_op(C_INIT, 24'h0, t);
        @(negedge clk); op_start = 1'b1; op_code = C_READ; op_block = 24'h777777;
        @(negedge clk); op_start = 1'b0;
        wait_done(d, 50, "busy_ignore_done");
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (cmd_log.size() - b != 1 || done_n - d != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: cmds=%0d dones=%0d busy=%b, required 1 1 0", cmd_log.size() - b, done_n - d, busy);
        end
        mgr_lat = 0;
    endtask

    task automatic test_reset_abort();
        int t, b, rb, mb, d, c, n, k;
        logic [23:0] blk;
        wq_t exp;
        rb = rd_log.size(); d = done_n; mgr_rand = 1;
        start_op(C_READ, 24'($urandom), t);
        n = 0;
        while (rd_log.size() < rb + 200 && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (rd_log.size() < rb + 200) begin
            errors++;
            $display("FAIL abort_reach: got %0d bytes, required 200", rd_log.size() - rb);
        end
        rst = 1'b1;
        #1;
        c = cmd_log.size(); d = done_n;
        checks++;
        if ({busy, op_done, op_err, rd_valid, rd_data, byte_idx, wr_req, cmd_word, cmd_start} !== 47'h0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b cmd_start=%b cmd_word=%h rd_valid=%b byte_idx=%0d, required all 0",
                     busy, cmd_start, cmd_word, rd_valid, byte_idx);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (cmd_log.size() != c || done_n != d || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: cmds=%0d dones=%0d busy=%b, required 0 0 0", cmd_log.size() - c, done_n - d, busy);
        end
        // fresh read with random block and data
        blk = 24'($urandom);
        b = cmd_log.size(); rb = rd_log.size(); mb = mgr_bytes.size(); d = done_n;
        start_op(C_READ, blk, t);
        wait_done(d, 20000, "post_reset_done");
        exp = read_cmds(blk);
        k = seq_diff(exp, b);
        checks++;
        if (k != -1) begin
            errors++;
            $display("FAIL post_reset_cmds: diff at %0d, got %0d words, required %0d", k, cmd_log.size() - b, exp.size());
        end
        k = -1;
        if (rd_log.size() - rb != BB || mgr_bytes.size() - mb != BB) k = -2;
        else for (int i = 0; i < BB; i++)
            if (rd_log[rb + i] !== mgr_bytes[mb + i] || rd_ilog[rb + i] !== 9'(i)) begin k = i; break; end
        checks++;
        if (k != -1) begin
            errors++;
            $display("FAIL post_reset_data: diff at %0d, got %0d bytes, required %0d manager bytes", k, rd_log.size() - rb, BB);
        end
        checks++;
        if (done_err !== 1'b0) begin errors++; $display("FAIL post_reset_err: got %b, required 0", done_err); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_read_pattern();
        test_write();
        test_timeout();
        test_ignored();
        test_reset_abort();
        repeat (3) @(negedge clk);
        checks++;
        if (idle_word_viol != 0 || busy_viol != 0) begin
            errors++;
            $display("FAIL protocol: cmd_word nonzero without strobe %0d times, op_done without busy %0d times, required 0 and 0",
                     idle_word_viol, busy_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_block_sequencer.md
# sd_block_sequencer

Hardware initiator for the SD disk manager: turns one host request (init card, read 512-byte block, write 512-byte block) into the manager's 24-bit command-word sequence, one command outstanding at a time. It streams read bytes out and pulls write bytes in. It sits between the CPU/DMA side and the disk manager, replacing CPU-driven per-byte command issue.

## Interface
- BLOCK_BYTES, 512, bytes per block transfer; byte counter width is clog2(BLOCK_BYTES).
- TIMEOUT, 1000000, maximum clk cycles spent in any wait-for-manager state before error.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- op_start  in  1  request pulse; sampled only when busy=0.
- op_code  in  2  0=INIT, 1=READ, 2=WRITE, 3=reserved.
- op_block  in  24  block number, captured on accepted op_start.
- busy  out  1  high from the cycle after accept until the op_done cycle, inclusive.
- op_done  out  1  one-cycle completion pulse.
- op_err  out  1  valid with op_done; 1 = timeout or reserved op_code.
- rd_valid  out  1  one-cycle pulse per read byte.
- rd_data  out  8  read byte, valid with rd_valid.
- byte_idx  out  9  index of current byte, 0..BLOCK_BYTES-1, valid with rd_valid / wr_req.
- wr_req  out  1  level; requests write byte byte_idx.
- wr_valid  in  1  host supplies wr_data; consumed only while wr_req=1.
- wr_data  in  8  write byte.
- cmd_word  out  24  manager command: [23:16] opcode, [15:0] operand; zero when cmd_start=0.
- cmd_start  out  1  one-cycle command strobe to manager.
- cmd_done  in  1  manager completion pulse (INIT, OREAD, READ, WRITEBYTE, CLOSE).
- res_valid  in  1  manager result pulse (READBYTE data, OWRITE open complete).
- res_data  in  8  manager result byte, valid with res_valid.

## Operation
- Manager opcodes: NOP 0, INIT 1, BLOCK 2, OREAD 3, OWRITE 4, READ 5, WRITEBYTE 6, READBYTE 7, CLOSE 8, BIGBLOCK 9.
- BLOCK and BIGBLOCK produce no response; next command issues the following cycle.
- INIT: INIT (operand 0) -> wait cmd_done -> op_done.
- READ: BIGBLOCK {8'h00, blk[23:16]} -> BLOCK blk[15:0] -> OREAD (0) wait cmd_done -> repeat BLOCK_BYTES times {READ (0) wait cmd_done -> READBYTE (0) wait res_valid -> rd_valid} -> CLOSE (0) wait cmd_done -> op_done.
- WRITE: BIGBLOCK -> BLOCK -> OWRITE blk[15:0] wait res_valid -> repeat {assert wr_req, wait wr_valid -> WRITEBYTE {8'h00, wr_data} wait cmd_done} -> CLOSE wait cmd_done -> op_done.
- States: IDLE, HI, LO, OPEN, WAIT_OPEN, XFER, WAIT_XFER, FETCH (read: READBYTE issue/wait; write: wr_req), CLOSE, WAIT_CLOSE, FINISH.
- op_code 3: no commands; op_done+op_err one cycle after accept.
- Timeout: watchdog restarts on each cmd_start; expiry in any WAIT_* state -> FINISH with op_err=1, no CLOSE issued. FETCH waiting on host (wr_req) is not timed.
- cmd_done/res_valid outside the matching wait state: ignored. Both in the same cycle: only the one expected by the current state counts.
- op_start while busy: ignored, no queueing.

## Timing
- Reset: all outputs 0, state IDLE, counters 0.
- Accept at cycle T -> first cmd_start at T+1; BIGBLOCK T+1, BLOCK T+2, OREAD/OWRITE T+3.
- Response earliest the cycle after cmd_start; next cmd_start the cycle after the response is sampled.
- rd_valid/rd_data/byte_idx registered: one cycle after res_valid.
- wr_req asserted the cycle after entering FETCH; wr_valid sampled while wr_req=1; WRITEBYTE issued next cycle, wr_req drops same cycle.
- byte_idx increments after each byte's final response; last byte BLOCK_BYTES-1 then CLOSE.
- op_done one cycle after the final cmd_done (or error); busy low the cycle after op_done.
- rst mid-operation: immediate abort to IDLE, no CLOSE, no op_done.

## Structure
- Shared package sd_pkg: manager opcode constants, op_code constants, state enum.
- Sub-module sd_watchdog: loadable down-counter, restart and expire ports, width clog2(TIMEOUT+1).

## Test plan
- INIT, manager acks cmd_done 5 cycles after start -> one cmd_word 24'h010000, op_done op_err=0 6 cycles after the INIT cmd_start.
- READ block 24'h12ABCD, model returns byte i&8'hFF -> commands 0x090012, 0x02ABCD, 0x030000, 512×(0x050000, 0x070000), 0x080000; 512 rd_valid data 0..255,0..255, byte_idx 0..511.
- WRITE block 24'h000010, host delays wr_valid 3 cycles per byte -> 0x090000, 0x020010, 0x040010, 512 WRITEBYTE 0x0600dd matching wr_data, CLOSE, op_err=0.
- Model never answers OREAD, TIMEOUT=100 -> op_done op_err=1 101 cycles after the OREAD strobe, no CLOSE.
- op_start during busy, op_code 3, stray cmd_done in IDLE -> ignored / immediate error done / no state change.
- rst asserted at byte 200 of a read -> all outputs 0 immediately; new READ afterwards completes normally.
